// File: rtl/pc_addr_unit.sv
// Program-counter and memory-address unit for the multicycle datapath.
// Covers PC-next source selection, PC write/branch/exception loading, misalign tracking and the memory address select.
module pc_addr_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NSRC       = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080),
  parameter int unsigned      ADDR_REG   = 0,
  localparam int unsigned     SELW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_bus_i,
  input  logic [SELW-1:0]       pc_src_i,
  input  logic                  pc_write_i,
  input  logic                  pc_write_cond_i,
  input  logic                  cond_zero_i,
  input  logic                  branch_ne_i,
  input  logic                  iord_i,
  input  logic [WIDTH-1:0]      data_addr_i,
  input  logic                  exc_req_i,
  input  logic                  clr_fault_i,
  output logic [WIDTH-1:0]      pc_o,
  output logic [WIDTH-1:0]      mem_addr_o,
  output logic [WIDTH-1:0]      epc_o,
  output logic                  misalign_o,
  output logic [WIDTH-1:0]      bad_vaddr_o,
  output logic                  pc_updated_o
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] bad_vaddr_q, bad_vaddr_d;
  logic             pc_updated_q, pc_updated_d;

  logic [WIDTH-1:0] target_s;
  logic             src_valid_s;
  logic             take_s;
  logic             target_misaligned_s;
  logic [WIDTH-1:0] mem_addr_s;

  // An out-of-range select leaves src_valid_s low, which suppresses the update.
  always_comb begin
    target_s    = '0;
    src_valid_s = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (pc_src_i == SELW'(i)) begin
        target_s    = src_bus_i[i*WIDTH +: WIDTH];
        src_valid_s = 1'b1;
      end else begin
        target_s    = target_s;
        src_valid_s = src_valid_s;
      end
    end
  end

  assign take_s = src_valid_s &
                  (pc_write_i | (pc_write_cond_i & (cond_zero_i ^ branch_ne_i)));
  assign target_misaligned_s = (target_s[1:0] != 2'b00);

  // Next-state for PC, EPC and fault state; exception beats take, fault beats aligned load.
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misalign_d   = misalign_q & ~clr_fault_i;
    bad_vaddr_d  = bad_vaddr_q;
    pc_updated_d = 1'b0;
    if (exc_req_i) begin
      pc_d         = EXC_VECTOR;
      epc_d        = pc_q;
      pc_updated_d = 1'b1;
    end else if (take_s && target_misaligned_s) begin
      misalign_d = 1'b1;
      // A clear in the same cycle opens a fresh fault window, so the new target is recorded.
      if (!misalign_q || clr_fault_i) begin
        bad_vaddr_d = target_s;
      end else begin
        bad_vaddr_d = bad_vaddr_q;
      end
    end else if (take_s) begin
      pc_d         = target_s;
      pc_updated_d = 1'b1;
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      epc_q        <= '0;
      misalign_q   <= 1'b0;
      bad_vaddr_q  <= '0;
      pc_updated_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misalign_q   <= misalign_d;
      bad_vaddr_q  <= bad_vaddr_d;
      pc_updated_q <= pc_updated_d;
    end
  end

  assign mem_addr_s = iord_i ? data_addr_i : pc_q;

  generate
    if (ADDR_REG != 0) begin : g_addr_reg
      logic [WIDTH-1:0] mem_addr_q;

      // Registered address: iord and pc sampled on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_addr_q <= RESET_PC;
        end else begin
          mem_addr_q <= mem_addr_s;
        end
      end

      assign mem_addr_o = mem_addr_q;
    end else begin : g_addr_comb
      assign mem_addr_o = mem_addr_s;
    end
  endgenerate

  assign pc_o         = pc_q;
  assign epc_o        = epc_q;
  assign misalign_o   = misalign_q;
  assign bad_vaddr_o  = bad_vaddr_q;
  assign pc_updated_o = pc_updated_q;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed bench for pc_addr_unit: a default instance (combinational address) and
// an NSRC=5 instance with registered address, checked through an expectation queue.
module tb_pc_addr_unit;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  // Instance A: NSRC=4, ADDR_REG=0
  logic [4*W-1:0] a_src_bus;
  logic [1:0]     a_pc_src;
  logic           a_pc_write, a_pc_write_cond, a_cond_zero, a_branch_ne;
  logic           a_iord, a_exc_req, a_clr_fault;
  logic [W-1:0]   a_data_addr;
  logic [W-1:0]   a_pc, a_mem_addr, a_epc, a_bad_vaddr;
  logic           a_misalign, a_pc_updated;

  // Instance B: NSRC=5, ADDR_REG=1
  logic [5*W-1:0] b_src_bus;
  logic [2:0]     b_pc_src;
  logic           b_pc_write, b_pc_write_cond, b_cond_zero, b_branch_ne;
  logic           b_iord, b_exc_req, b_clr_fault;
  logic [W-1:0]   b_data_addr;
  logic [W-1:0]   b_pc, b_mem_addr, b_epc, b_bad_vaddr;
  logic           b_misalign, b_pc_updated;

  pc_addr_unit #(.WIDTH(32), .NSRC(4), .RESET_PC(32'h0000_0000),
                 .EXC_VECTOR(32'h0000_0080), .ADDR_REG(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .src_bus_i(a_src_bus), .pc_src_i(a_pc_src),
    .pc_write_i(a_pc_write), .pc_write_cond_i(a_pc_write_cond),
    .cond_zero_i(a_cond_zero), .branch_ne_i(a_branch_ne), .iord_i(a_iord),
    .data_addr_i(a_data_addr), .exc_req_i(a_exc_req), .clr_fault_i(a_clr_fault),
    .pc_o(a_pc), .mem_addr_o(a_mem_addr), .epc_o(a_epc), .misalign_o(a_misalign),
    .bad_vaddr_o(a_bad_vaddr), .pc_updated_o(a_pc_updated));

  pc_addr_unit #(.WIDTH(32), .NSRC(5), .RESET_PC(32'h0000_0000),
                 .EXC_VECTOR(32'h0000_0080), .ADDR_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .src_bus_i(b_src_bus), .pc_src_i(b_pc_src),
    .pc_write_i(b_pc_write), .pc_write_cond_i(b_pc_write_cond),
    .cond_zero_i(b_cond_zero), .branch_ne_i(b_branch_ne), .iord_i(b_iord),
    .data_addr_i(b_data_addr), .exc_req_i(b_exc_req), .clr_fault_i(b_clr_fault),
    .pc_o(b_pc), .mem_addr_o(b_mem_addr), .epc_o(b_epc), .misalign_o(b_misalign),
    .bad_vaddr_o(b_bad_vaddr), .pc_updated_o(b_pc_updated));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {A_PC, A_EPC, A_MIS, A_BAD, A_UPD, A_MEM,
                    B_PC, B_UPD, B_MEM} sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;

  function automatic logic [31:0] obs(sel_t s);
    case (s)
      A_PC:    return a_pc;
      A_EPC:   return a_epc;
      A_MIS:   return {31'd0, a_misalign};
      A_BAD:   return a_bad_vaddr;
      A_UPD:   return {31'd0, a_pc_updated};
      A_MEM:   return a_mem_addr;
      B_PC:    return b_pc;
      B_UPD:   return {31'd0, b_pc_updated};
      B_MEM:   return b_mem_addr;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input sel_t sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      ntests++;
      assert (o === e.exp) else begin
        nfail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    a_src_bus = '0; a_pc_src = 2'd0; a_pc_write = 1'b0; a_pc_write_cond = 1'b0;
    a_cond_zero = 1'b0; a_branch_ne = 1'b0; a_iord = 1'b0; a_exc_req = 1'b0;
    a_clr_fault = 1'b0; a_data_addr = '0;
    b_src_bus = '0; b_pc_src = 3'd0; b_pc_write = 1'b0; b_pc_write_cond = 1'b0;
    b_cond_zero = 1'b0; b_branch_ne = 1'b0; b_iord = 1'b0; b_exc_req = 1'b0;
    b_clr_fault = 1'b0; b_data_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    push("rst_pc", A_PC, 32'h0); push("rst_epc", A_EPC, 32'h0);
    push("rst_mis", A_MIS, 32'h0); push("rst_bad", A_BAD, 32'h0);
    push("rst_upd", A_UPD, 32'h0); push("rst_mem", A_MEM, 32'h0);
    push("rst_b_mem", B_MEM, 32'h0); push("rst_b_pc", B_PC, 32'h0);
    check_all();
    #2 rst_n = 1'b1;

    // Unconditional write from source 0
    @(posedge clk); #1;
    a_src_bus[0*W +: W] = 32'h4; a_pc_src = 2'd0; a_pc_write = 1'b1;
    push("wr_pc", A_PC, 32'h4); push("wr_upd", A_UPD, 32'h1); push("wr_mem", A_MEM, 32'h4);
    step();
    a_pc_write = 1'b0;
    push("wr_hold_pc", A_PC, 32'h4); push("wr_upd_pulse", A_UPD, 32'h0);
    step();

    // Conditional branches from source 1
    a_src_bus[1*W +: W] = 32'h40; a_pc_src = 2'd1;
    a_pc_write_cond = 1'b1; a_cond_zero = 1'b1; a_branch_ne = 1'b0;
    push("beq_taken_pc", A_PC, 32'h40); push("beq_taken_upd", A_UPD, 32'h1);
    step();
    a_branch_ne = 1'b1;
    push("bne_zero_pc", A_PC, 32'h40); push("bne_zero_upd", A_UPD, 32'h0);
    step();
    a_src_bus[1*W +: W] = 32'h44; a_cond_zero = 1'b0;
    push("bne_taken_pc", A_PC, 32'h44); push("bne_taken_upd", A_UPD, 32'h1);
    step();
    a_pc_write_cond = 1'b0; a_pc_write = 1'b1; a_pc_src = 2'd0;
    a_src_bus[0*W +: W] = 32'h48;
    push("b2b_pc", A_PC, 32'h48); push("b2b_upd", A_UPD, 32'h1);
    step();

    // Misaligned targets
    a_src_bus[0*W +: W] = 32'h102;
    push("mis1_pc", A_PC, 32'h48); push("mis1_flag", A_MIS, 32'h1);
    push("mis1_bad", A_BAD, 32'h102); push("mis1_upd", A_UPD, 32'h0);
    step();
    a_src_bus[0*W +: W] = 32'h205;
    push("mis2_bad", A_BAD, 32'h102); push("mis2_flag", A_MIS, 32'h1);
    step();
    a_src_bus[0*W +: W] = 32'h307; a_clr_fault = 1'b1;
    push("clrset_flag", A_MIS, 32'h1); push("clrset_bad", A_BAD, 32'h307);
    step();
    a_clr_fault = 1'b0; a_src_bus[0*W +: W] = 32'h20;
    push("align_pc", A_PC, 32'h20); push("align_mis", A_MIS, 32'h1);
    step();

    // Exception overrides a misaligned take
    a_exc_req = 1'b1; a_src_bus[0*W +: W] = 32'h3;
    push("exc_pc", A_PC, 32'h80); push("exc_epc", A_EPC, 32'h20);
    push("exc_mis", A_MIS, 32'h1); push("exc_bad", A_BAD, 32'h307);
    push("exc_upd", A_UPD, 32'h1);
    step();
    a_exc_req = 1'b0; a_pc_write = 1'b0; a_clr_fault = 1'b1;
    push("clr_mis", A_MIS, 32'h0); push("clr_bad", A_BAD, 32'h307);
    push("clr_pc", A_PC, 32'h80);
    step();
    a_clr_fault = 1'b0;

    // Combinational address select
    a_iord = 1'b1; a_data_addr = 32'h1000;
    #1 push("iord_data", A_MEM, 32'h1000); check_all();
    a_iord = 1'b0;
    #1 push("iord_pc", A_MEM, 32'h80); check_all();

    // Asynchronous reset during an exception request
    @(posedge clk); #1;
    a_exc_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    push("arst_pc", A_PC, 32'h0); push("arst_epc", A_EPC, 32'h0);
    push("arst_mis", A_MIS, 32'h0); push("arst_bad", A_BAD, 32'h0);
    push("arst_upd", A_UPD, 32'h0); push("arst_mem", A_MEM, 32'h0);
    check_all();
    @(posedge clk); #1;
    a_exc_req = 1'b0;
    #2 rst_n = 1'b1;
    push("post_rst_pc", A_PC, 32'h0); push("post_rst_epc", A_EPC, 32'h0);
    step();

    // Registered address instance
    b_iord = 1'b1; b_data_addr = 32'h1000;
    #1 push("b_mem_lat0", B_MEM, 32'h0); check_all();
    push("b_mem_lat1", B_MEM, 32'h1000);
    step();
    b_iord = 1'b0;
    for (int i = 0; i < 5; i++) b_src_bus[i*W +: W] = 32'h500 + 32'(i) * 32'h10;
    b_pc_src = 3'd5; b_pc_write = 1'b1;
    push("b_oor5_pc", B_PC, 32'h0); push("b_oor5_upd", B_UPD, 32'h0);
    push("b_mem_pc", B_MEM, 32'h0);
    step();
    b_pc_src = 3'd7;
    push("b_oor7_pc", B_PC, 32'h0);
    step();
    b_pc_src = 3'd4;
    push("b_src4_pc", B_PC, 32'h540); push("b_src4_upd", B_UPD, 32'h1);
    push("b_mem_old_pc", B_MEM, 32'h0);
    step();
    b_pc_write = 1'b0;
    push("b_mem_new_pc", B_MEM, 32'h540); push("b_upd_pulse", B_UPD, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
